spi_master_engine: RTL
======================

Name: spi_master_engine

Overview:
- SPI master shift engine sitting directly downstream of the AXI-Lite slave interface inside the AXI-to-SPI top level.
- The AXI register logic hands it one word per transfer over a valid/ready handshake.
- The engine serialises the word on SPI_MOSI in SPI mode 0 (CPOL=0, CPHA=0), MSB first, while capturing SPI_MISO.
- It returns the received word with a one-cycle valid pulse for the register logic to latch into its read-data register.

Parameters:
- DATA_WIDTH, 8, bits per SPI transfer; legal range 2..32.
- CLK_DIV, 4, ACLK cycles per SCK half-period; legal range 1..255.

Ports:
- ACLK  input  1  system clock; all logic on its rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- tx_valid  input  1  tx_data holds a word to transmit.
- tx_ready  output  1  engine can accept a word.
- tx_data  input  DATA_WIDTH  word to transmit, MSB first.
- rx_valid  output  1  one-cycle pulse; rx_data holds a new received word.
- rx_data  output  DATA_WIDTH  last received word; held until the next transfer completes.
- busy  output  1  transfer in progress.
- SPI_SCK  output  1  serial clock, idle low.
- SPI_MOSI  output  1  serial data out.
- SPI_MISO  input  1  serial data in.

Behaviour:
- Reset, asynchronous, while ARESETn=0:
  - state=IDLE, tx_ready=1, rx_valid=0, rx_data=0, busy=0, SPI_SCK=0, SPI_MOSI=0.
  - Divider, bit counter and shift register all clear.
- Reset mid-transfer: the transfer is abandoned immediately, with no rx_valid pulse.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - tx_ready=1.
  - Accept occurs on a rising edge where tx_valid & tx_ready.
  - At accept: shift register <= tx_data; SPI_MOSI <= tx_data[MSB]; divider <= 0; bit counter <= 0; go to SHIFT.
  - tx_valid while not ready is ignored; the upstream must hold it.
- SHIFT:
  - tx_ready=0, busy=1.
  - The divider counts 0..CLK_DIV-1. At terminal count it wraps to 0 and SPI_SCK toggles.
  - Rising SCK toggle (0->1): sample SPI_MISO into the shift-register LSB side.
  - Falling SCK toggle (1->0), not the last bit: shift left and drive the next bit on SPI_MOSI; bit counter +1.
  - Falling toggle of bit DATA_WIDTH-1: go to DONE, with SPI_SCK=0.
  - SPI_MOSI is stable for a full SCK period around each rising edge.
- DONE (one cycle):
  - rx_data <= captured word; rx_valid=1; busy=0; tx_ready=1.
  - A tx_valid in this cycle is accepted and starts the next transfer back-to-back.
  - Next state is SHIFT if a word was accepted, otherwise IDLE.
- Timing:
  - First SCK rise is CLK_DIV cycles after the accept edge.
  - rx_valid is high in cycle 2*DATA_WIDTH*CLK_DIV+1 after the accept edge.
  - Exactly DATA_WIDTH SCK pulses per transfer.
- rx_valid has no backpressure: a consumer that misses the pulse loses the word, but rx_data still holds it.
- SPI_MOSI holds its last driven bit in IDLE.
- CLK_DIV=1 is legal: SCK = ACLK/2.

Optional Feature:
- Macro: SPI_CSN_EN.
- Defined:
  - Extra output SPI_CSN (1 bit, active low, reset value 1).
  - SPI_CSN falls on the accept edge; the first SCK rise is delayed by an additional CLK_DIV cycles of setup.
  - SPI_CSN rises CLK_DIV cycles after the final SCK fall (hold); DONE follows this rise.
  - Back-to-back transfers deassert SPI_CSN for at least one ACLK cycle.
  - All latencies above grow by 2*CLK_DIV.
- Undefined:
  - No SPI_CSN port; chip select is handled externally.
  - Timing exactly as in Behaviour.

Test Plan:
- Reset: hold ARESETn=0 for 5 cycles with random inputs -> tx_ready=1, rx_valid=0, SPI_SCK=0, SPI_MOSI=0, rx_data=0.
- Loopback, DATA_WIDTH=8, CLK_DIV=2, SPI_MISO tied to SPI_MOSI, send 0xA5:
  - MOSI bit sequence at SCK rises is 1,0,1,0,0,1,0,1.
  - 8 SCK pulses; rx_valid at cycle 33 after accept; rx_data=0xA5.
- Slave model returns 0x3C while sending 0xFF with CLK_DIV=1 -> rx_data=0x3C; rx_valid at cycle 17; SCK period 2 ACLK cycles.
- Back-to-back: tx_valid held high with 0x01 then 0x80 -> second accept in the DONE cycle of the first, with no idle gap on SCK timing; two rx_valid pulses 33 cycles apart.
- Reset mid-transfer: assert ARESETn=0 after the 4th SCK rise -> all outputs return to reset values immediately; no rx_valid; a fresh transfer of 0x5A afterwards completes correctly.
- With SPI_CSN_EN, CLK_DIV=2, send 0x81:
  - SPI_CSN low on the accept edge; first SCK rise 4 cycles later.
  - SPI_CSN high 2 cycles after the last SCK fall; rx_valid at cycle 37.

Source files
------------

// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: one word per valid/ready handshake, MSB first, full duplex.
// Optional chip select with setup/hold phases is built in when SPI_CSN_EN is defined.
module spi_master_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  SPI_SCK,
    output logic                  SPI_MOSI,
`ifdef SPI_CSN_EN
    output logic                  SPI_CSN,
`endif
    input  logic                  SPI_MISO
);

    // state  | meaning
    // IDLE   | waiting for a word, tx_ready high
    // SETUP  | chip select asserted, CLK_DIV cycles before first SCK rise (SPI_CSN_EN only)
    // SHIFT  | SCK toggling, MOSI driven on falls, MISO sampled on rises
    // HOLD   | CLK_DIV cycles after last SCK fall before CSN rises (SPI_CSN_EN only)
    // DONE   | one cycle: rx_valid pulse, next word may be accepted
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
`ifdef SPI_CSN_EN
    localparam logic [2:0] ST_SETUP = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
`endif

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [2:0]            state;
    logic [DIV_W-1:0]      div_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  miso_q;
    logic                  div_tc;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rx_word;

    assign tx_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign busy     = ~tx_ready;
    assign rx_valid = (state == ST_DONE);
    assign div_tc   = (div_cnt == DIV_TC);
    assign accept   = tx_valid & tx_ready;
    // the bit sampled on the last rise completes the word without an extra shift cycle
    assign rx_word  = {shift_reg[DATA_WIDTH-2:0], miso_q};

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            miso_q    <= 1'b0;
            rx_data   <= '0;
            SPI_SCK   <= 1'b0;
            SPI_MOSI  <= 1'b0;
`ifdef SPI_CSN_EN
            SPI_CSN   <= 1'b1;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        shift_reg <= tx_data;
                        SPI_MOSI  <= tx_data[DATA_WIDTH-1];
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
`ifdef SPI_CSN_EN
                        SPI_CSN   <= 1'b0;
                        state     <= ST_SETUP;
`else
                        state     <= ST_SHIFT;
`endif
                    end else begin
                        state <= ST_IDLE;
                    end
                end

`ifdef SPI_CSN_EN
                ST_SETUP: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
`endif

                ST_SHIFT: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        SPI_SCK <= ~SPI_SCK;
                        if (!SPI_SCK) begin
                            miso_q <= SPI_MISO;
                        end else if (bit_cnt == BIT_LAST) begin
`ifdef SPI_CSN_EN
                            shift_reg <= rx_word;
                            state     <= ST_HOLD;
`else
                            rx_data   <= rx_word;
                            state     <= ST_DONE;
`endif
                        end else begin
                            shift_reg <= rx_word;
                            SPI_MOSI  <= shift_reg[DATA_WIDTH-2];
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

`ifdef SPI_CSN_EN
                ST_HOLD: begin
                    if (div_tc) begin
                        div_cnt <= '0;
                        SPI_CSN <= 1'b1;
                        rx_data <= shift_reg;
                        state   <= ST_DONE;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
